// File: rtl/coo_issue_scheduler_pkg.sv
// Shared types for the COO issue scheduler: FSM states, the per-lane head entry,
// and the sentinel-row helper that marks an idle accumulator lane.
package sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      GAP,
      TERM,
      WAIT_DONE,
      DONE
   } state_t;

   typedef struct packed {
      logic [31:0] value;
      logic [31:0] col;
      logic [31:0] row;
      logic        last;
   } lane_entry_t;

   // The row index one past the matrix tells the accumulator "no work this lane".
   function automatic logic [31:0] sentinel_row(input int matrix_size);
      return 32'(matrix_size);
   endfunction

   function automatic int ptr_width(input int num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

endpackage

// File: rtl/coo_issue_scheduler_if.sv
// Lane-stream and accumulator-beat bus between the COO scheduler (master) and
// its environment: per-lane head entries in, packed accumulator beats out.
interface coo_issue_scheduler_if #(
   parameter int NUM_CHANNELS = 4
);
   logic [NUM_CHANNELS-1:0]       in_valid;
   logic [NUM_CHANNELS-1:0]       in_ready;
   logic [NUM_CHANNELS-1:0][31:0] in_value;
   logic [NUM_CHANNELS-1:0][31:0] in_col;
   logic [NUM_CHANNELS-1:0][31:0] in_row;
   logic [NUM_CHANNELS-1:0]       in_last;
   logic [NUM_CHANNELS-1:0][31:0] values;
   logic [NUM_CHANNELS-1:0][31:0] col_id;
   logic [NUM_CHANNELS-1:0][31:0] row_id;
   logic                          rdy;
   logic                          acc_done;

   modport master (
      input  in_valid, in_value, in_col, in_row, in_last, acc_done,
      output in_ready, values, col_id, row_id, rdy
   );

   modport slave (
      output in_valid, in_value, in_col, in_row, in_last, acc_done,
      input  in_ready, values, col_id, row_id, rdy
   );
endinterface

// File: rtl/coo_issue_scheduler_rr_conflict_arbiter.sv
// Round-robin row-conflict arbiter: starting at lane ptr, grants each eligible
// in-range lane whose row is not already claimed this beat; out-of-range rows are dropped.
module rr_conflict_arbiter
   import sched_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int MATRIX_SIZE  = 128
) (
   input  logic [NUM_CHANNELS-1:0]       eligible,
   input  logic [NUM_CHANNELS-1:0][31:0] row,
   input  logic [ptr_width(NUM_CHANNELS)-1:0] ptr,
   output logic [NUM_CHANNELS-1:0]       grant,
   output logic [NUM_CHANNELS-1:0]       drop,
   output logic                          conflict
);
   localparam int PW = ptr_width(NUM_CHANNELS);
   localparam int SW = PW + 1;
   localparam logic [31:0] SENTINEL = sentinel_row(MATRIX_SIZE);

   logic [SW-1:0] lane_sum;
   logic [PW-1:0] lane;
   logic          row_hit;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path can infer a latch.
      grant    = '0;
      drop     = '0;
      conflict = 1'b0;
      lane_sum = '0;
      lane     = '0;
      row_hit  = 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         lane_sum = {1'b0, ptr} + SW'(k);
         if (lane_sum >= SW'(NUM_CHANNELS)) begin
            lane_sum = lane_sum - SW'(NUM_CHANNELS);
         end
         lane = lane_sum[PW-1:0];
         // Only lanes earlier in this beat's visiting order can already hold a grant.
         row_hit = 1'b0;
         for (int j = 0; j < NUM_CHANNELS; j++) begin
            if (grant[j] && (row[j] == row[lane])) begin
               row_hit = 1'b1;
            end
         end
         if (eligible[lane]) begin
            if (row[lane] >= SENTINEL) begin
               drop[lane] = 1'b1;
            end else if (row_hit) begin
               conflict = 1'b1;
            end else begin
               grant[lane] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/coo_issue_scheduler.sv
// COO issue scheduler: packs per-lane nonzeros into conflict-free accumulator beats
// at a two-cycle cadence, then closes with a sentinel beat. Optional SCHED_STATS_EN adds counters.
module coo_issue_scheduler
   import sched_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int MATRIX_SIZE  = 128
) (
   input  logic                         clk,
   input  logic                         rst_l,
   input  logic                         start,
   coo_issue_scheduler_if.master        bus,
   output logic                         busy,
   output logic                         done,
   output logic                         err
`ifdef SCHED_STATS_EN
   ,
   output logic [31:0]                  beat_count,
   output logic [31:0]                  conflict_count
`endif
);
   localparam int PW = ptr_width(NUM_CHANNELS);
   localparam logic [31:0] SENTINEL = sentinel_row(MATRIX_SIZE);

   state_t state, state_nxt;
   logic [PW-1:0]                 ptr;
   logic [NUM_CHANNELS-1:0]       finished;
   logic [NUM_CHANNELS-1:0]       eligible;
   logic [NUM_CHANNELS-1:0]       grant;
   logic [NUM_CHANNELS-1:0]       drop;
   logic [NUM_CHANNELS-1:0]       pop;
   logic [NUM_CHANNELS-1:0]       head_last;
   logic [NUM_CHANNELS-1:0][31:0] head_row;
   lane_entry_t [NUM_CHANNELS-1:0] head;
   logic conflict;
   logic any_grant;
   logic all_finished;
   logic in_arb;
   logic issue_data;
   logic issue_term;
   logic issue_beat;

   logic [NUM_CHANNELS-1:0][31:0] values_q;
   logic [NUM_CHANNELS-1:0][31:0] col_q;
   logic [NUM_CHANNELS-1:0][31:0] row_q;
   logic                          rdy_q;

   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         head[i] = '{value: bus.in_value[i], col: bus.in_col[i],
                     row: bus.in_row[i], last: bus.in_last[i]};
         head_row[i]  = head[i].row;
         head_last[i] = head[i].last;
      end
   end

   // Finished lanes are ignored regardless of what their stream presents.
   assign eligible = bus.in_valid & ~finished;

   rr_conflict_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .MATRIX_SIZE  (MATRIX_SIZE)
   ) u_arbiter (
      .eligible (eligible),
      .row      (head_row),
      .ptr      (ptr),
      .grant    (grant),
      .drop     (drop),
      .conflict (conflict)
   );

   assign any_grant    = |grant;
   assign all_finished = &finished;
   assign in_arb       = (state == ARB);
   assign issue_data   = in_arb && any_grant;
   assign issue_term   = in_arb && !any_grant && all_finished;
   assign issue_beat   = issue_data || issue_term;

   // Pops are masked while reset is held so a mid-run reset consumes nothing.
   assign pop          = (in_arb && rst_l) ? (grant | drop) : '0;
   assign bus.in_ready = pop;

   assign bus.values = values_q;
   assign bus.col_id = col_q;
   assign bus.row_id = row_q;
   assign bus.rdy    = rdy_q;

   assign busy = (state == ARB) || (state == GAP) || (state == TERM) || (state == WAIT_DONE);
   assign done = (state == DONE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (start) state_nxt = ARB;
         ARB: begin
            if (any_grant) begin
               state_nxt = GAP;
            end else if (all_finished) begin
               state_nxt = TERM;
            end
         end
         GAP:       state_nxt = ARB;
         TERM:      state_nxt = WAIT_DONE;
         WAIT_DONE: if (bus.acc_done) state_nxt = DONE;
         DONE:      state_nxt = DONE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (!rst_l) begin
         state    <= IDLE;
         ptr      <= '0;
         finished <= '0;
         err      <= 1'b0;
         rdy_q    <= 1'b0;
         values_q <= '0;
         col_q    <= '0;
         row_q    <= {NUM_CHANNELS{SENTINEL}};
      end else begin
         state <= state_nxt;
         rdy_q <= issue_beat;
         if ((state == IDLE) && start) begin
            finished <= '0;
            ptr      <= '0;
         end else if (in_arb) begin
            finished <= finished | (pop & head_last);
            if (|(pop & drop)) begin
               err <= 1'b1;
            end
            if (issue_data) begin
               ptr <= (ptr == PW'(NUM_CHANNELS - 1)) ? '0 : ptr + 1'b1;
            end
         end
         // Non-granted lanes carry the sentinel; a termination beat has no grants at all.
         if (issue_beat) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
               values_q[i] <= grant[i] ? head[i].value : 32'd0;
               col_q[i]    <= grant[i] ? head[i].col   : 32'd0;
               row_q[i]    <= grant[i] ? head[i].row   : SENTINEL;
            end
         end
      end
   end

`ifdef SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         beat_count     <= '0;
         conflict_count <= '0;
      end else begin
         if (issue_data && (beat_count != '1)) begin
            beat_count <= beat_count + 32'd1;
         end
         if (issue_data && conflict && (conflict_count != '1)) begin
            conflict_count <= conflict_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_coo_issue_scheduler.sv
// Randomised scoreboard bench for coo_issue_scheduler: a queue-based lane model predicts
// pops and beats; a separate negedge monitor compares each rdy beat against the scoreboard.
module tb_coo_issue_scheduler;
   localparam int N  = 4;
   localparam int MS = 128;
   localparam logic [31:0] SENT = 32'd128;

   typedef struct {
      logic [31:0] value;
      logic [31:0] col;
      logic [31:0] row;
      bit          last;
   } ent_t;

   typedef struct packed {
      logic [N-1:0][31:0] v;
      logic [N-1:0][31:0] c;
      logic [N-1:0][31:0] r;
   } beat_t;

   typedef enum int {M_IDLE, M_ARB, M_GAP, M_TERM, M_WAIT, M_DONE} mphase_t;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   logic start = 1'b0;
   logic busy, done, err;
`ifdef SCHED_STATS_EN
   logic [31:0] beat_count, conflict_count;
`endif

   coo_issue_scheduler_if #(.NUM_CHANNELS(N)) bus ();

   coo_issue_scheduler #(
      .NUM_CHANNELS (N),
      .MATRIX_SIZE  (MS)
   ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err)
`ifdef SCHED_STATS_EN
      ,
      .beat_count     (beat_count),
      .conflict_count (conflict_count)
`endif
   );

   always #5 clk = ~clk;

   int      n_checks = 0;
   int      n_fail   = 0;
   ent_t    lane_q [N][$];
   beat_t   sb [$];
   mphase_t m_phase = M_IDLE;
   int      m_p     = 0;
   bit [N-1:0] m_fin = '0;
   bit      m_err   = 1'b0;
   int      m_beats = 0;
   int      m_conf  = 0;
   int      stall [N];
   int      valid_pct = 100;
   bit      prev_rdy  = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rdy strobe must match the oldest predicted beat.
   always @(negedge clk) begin
      beat_t e;
      if (bus.rdy) begin
         check("rdy_back_to_back", {127'd0, prev_rdy}, 128'd0);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got row_id=%0h, expected no beat", bus.row_id);
         end else begin
            e = sb.pop_front();
            check("beat_row_id", bus.row_id, e.r);
            check("beat_values", bus.values, e.v);
            check("beat_col_id", bus.col_id, e.c);
         end
      end
      prev_rdy <= bus.rdy;
   end

   task automatic model_reset();
      m_phase = M_IDLE;
      m_p     = 0;
      m_fin   = '0;
      m_err   = 1'b0;
      m_beats = 0;
      m_conf  = 0;
   endtask

   // Reference model: one call per cycle, using the inputs the bench applied this cycle.
   task automatic model_step();
      logic [N-1:0] g = '0;
      logic [N-1:0] d = '0;
      bit    conf = 1'b0;
      bit    all_fin;
      ent_t  hd [N];
      beat_t b;
      check("busy", busy, (m_phase == M_ARB) || (m_phase == M_GAP) ||
                          (m_phase == M_TERM) || (m_phase == M_WAIT));
      check("done", done, m_phase == M_DONE);
      check("err", err, m_err);
      if (rst_l && (m_phase == M_ARB)) begin
         logic [31:0] taken [$];
         for (int k = 0; k < N; k++) begin
            int ln;
            bit hit;
            ln = (m_p + k) % N;
            if (bus.in_valid[ln] && !m_fin[ln]) begin
               hd[ln] = lane_q[ln][0];
               if (hd[ln].row >= MS) begin
                  d[ln] = 1'b1;
               end else begin
                  hit = 1'b0;
                  foreach (taken[t]) if (taken[t] == hd[ln].row) hit = 1'b1;
                  if (hit) conf = 1'b1;
                  else begin
                     g[ln] = 1'b1;
                     taken.push_back(hd[ln].row);
                  end
               end
            end
         end
      end
      check("in_ready", bus.in_ready, g | d);
      if (!rst_l) begin
         model_reset();
         return;
      end
      case (m_phase)
         M_IDLE: if (start) begin
            m_phase = M_ARB;
            m_p     = 0;
            m_fin   = '0;
         end
         M_ARB: begin
            all_fin = &m_fin;
            for (int ln = 0; ln < N; ln++) begin
               if (g[ln] || d[ln]) begin
                  lane_q[ln].delete(0);
                  if (hd[ln].last) m_fin[ln] = 1'b1;
                  if (d[ln]) m_err = 1'b1;
               end
            end
            if (|g) begin
               for (int i = 0; i < N; i++) begin
                  b.r[i] = g[i] ? hd[i].row   : SENT;
                  b.v[i] = g[i] ? hd[i].value : 32'd0;
                  b.c[i] = g[i] ? hd[i].col   : 32'd0;
               end
               sb.push_back(b);
               m_p     = (m_p + 1) % N;
               m_phase = M_GAP;
               m_beats++;
               if (conf) m_conf++;
            end else if (all_fin) begin
               b.r = {N{SENT}};
               b.v = '0;
               b.c = '0;
               sb.push_back(b);
               m_phase = M_TERM;
            end
         end
         M_GAP:  m_phase = M_ARB;
         M_TERM: m_phase = M_WAIT;
         M_WAIT: if (bus.acc_done) m_phase = M_DONE;
         default: ;
      endcase
   endtask

   task automatic drive(input bit st, input bit ad, input bit rst);
      @(posedge clk);
      #1;
      rst_l        = !rst;
      start        = st;
      bus.acc_done = ad;
      for (int i = 0; i < N; i++) begin
         if (stall[i] > 0) begin
            bus.in_valid[i] = 1'b0;
            stall[i]--;
         end else begin
            bus.in_valid[i] = ($urandom_range(99) < valid_pct);
         end
         if (lane_q[i].size() > 0) begin
            bus.in_value[i] = lane_q[i][0].value;
            bus.in_col[i]   = lane_q[i][0].col;
            bus.in_row[i]   = lane_q[i][0].row;
            bus.in_last[i]  = lane_q[i][0].last;
         end else begin
            bus.in_value[i] = $urandom;
            bus.in_col[i]   = $urandom;
            bus.in_row[i]   = 32'($urandom_range(7));
            bus.in_last[i]  = 1'($urandom_range(1));
         end
      end
      @(negedge clk);
      model_step();
   endtask

   task automatic push_ent(input int ln, input logic [31:0] row, input logic [31:0] value,
                           input logic [31:0] col, input bit last);
      ent_t e;
      e.row   = row;
      e.value = value;
      e.col   = col;
      e.last  = last;
      lane_q[ln].push_back(e);
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < N; i++) begin
         lane_q[i].delete();
         stall[i] = 0;
      end
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      clear_lanes();
   endtask

   task automatic run_to_done(input string tag, input int budget);
      int wait_cnt;
      bit reached;
      bit ad;
      wait_cnt = $urandom_range(4);
      reached  = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      for (int cyc = 0; cyc < budget && !reached; cyc++) begin
         ad = 1'b0;
         if (m_phase == M_WAIT) begin
            if (wait_cnt == 0) ad = 1'b1;
            else wait_cnt--;
         end else if ($urandom_range(15) == 0) begin
            ad = 1'b1;
         end
         drive(1'b0, ad, 1'b0);
         if (m_phase == M_DONE) reached = 1'b1;
      end
      if (!reached) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no completion, expected done within %0d cycles", tag, budget);
      end
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      check("sb_drained", 128'(sb.size()), 128'd0);
`ifdef SCHED_STATS_EN
      check("beat_count", beat_count, m_beats);
      check("conflict_count", conflict_count, m_conf);
`endif
   endtask

   task automatic load_distinct(input int depth);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < depth; k++)
            push_ent(i, 32'(i * depth + k), 32'(1000 + i * 16 + k), 32'(i * 4 + k), k == depth - 1);
   endtask

   initial begin
      bus.in_valid = '0;
      bus.in_value = '0;
      bus.in_col   = '0;
      bus.in_row   = '0;
      bus.in_last  = '0;
      bus.acc_done = 1'b0;
      for (int i = 0; i < N; i++) stall[i] = 0;

      do_reset();
      check("reset_rdy", bus.rdy, 1'b0);
      check("reset_row_id", bus.row_id, {N{SENT}});
      check("reset_values", bus.values, '0);
      check("reset_col_id", bus.col_id, '0);

      // Distinct rows, single beat, then termination.
      valid_pct = 100;
      for (int i = 0; i < N; i++) push_ent(i, 32'(i), 32'(100 + i), 32'(10 + i), 1'b1);
      run_to_done("distinct", 200);

      // Every lane targets row 5: four serialised beats.
      do_reset();
      for (int i = 0; i < N; i++) push_ent(i, 32'd5, 32'(200 + i), 32'(20 + i), 1'b1);
      run_to_done("same_row", 200);

      // Continuous streams with disjoint rows: back-to-back beats at full cadence.
      do_reset();
      load_distinct(8);
      run_to_done("streaming", 300);

      // Lane 2 stalls while the others drain.
      do_reset();
      for (int i = 0; i < N; i++) push_ent(i, 32'(i + 40), 32'(300 + i), 32'(30 + i), 1'b1);
      stall[2] = 10;
      run_to_done("stall", 200);

      // Out-of-range heads are dropped, including one that only differs above bit 7.
      do_reset();
      push_ent(0, 32'd0, 32'd400, 32'd40, 1'b1);
      push_ent(1, 32'd200, 32'd401, 32'd41, 1'b0);
      push_ent(1, 32'd1, 32'd402, 32'd42, 1'b1);
      push_ent(2, 32'd2, 32'd403, 32'd43, 1'b1);
      push_ent(3, 32'h8000_0002, 32'd404, 32'd44, 1'b0);
      push_ent(3, 32'd3, 32'd405, 32'd45, 1'b1);
      run_to_done("drop", 200);

      // Reset asserted while a beat is on the bus, then a clean rerun.
      do_reset();
      load_distinct(4);
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 20 && m_phase != M_GAP; c++) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check("gap_reset_rdy", bus.rdy, 1'b0);
      check("gap_reset_row_id", bus.row_id, {N{SENT}});
      check("gap_reset_busy", busy, 1'b0);
      clear_lanes();
      for (int i = 0; i < N; i++) push_ent(i, 32'(i), 32'(500 + i), 32'(50 + i), 1'b1);
      run_to_done("after_reset", 200);

      // Randomised runs with collisions, drops and stalls.
      for (int iter = 0; iter < 25; iter++) begin
         do_reset();
         valid_pct = $urandom_range(100, 40);
         for (int i = 0; i < N; i++) begin
            int len;
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
               logic [31:0] row;
               case ($urandom_range(9))
                  0:       row = 32'd200;
                  1:       row = 32'h8000_0003;
                  default: row = 32'($urandom_range(7));
               endcase
               push_ent(i, row, $urandom, $urandom, k == len - 1);
            end
         end
         run_to_done("random", 600);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
